// File: rtl/mem_line_responder_pkg.sv
// Shared types and widths for the 128-bit line responder.
package mem_line_pkg;

    localparam int LINE_W  = 128;
    localparam int LADDR_W = 28;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2,
        S_GAP  = 2'd3
    } state_e;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_e;

endpackage

// File: rtl/mem_line_responder_if.sv
// Cache-side line bus: request held by the master until the one-cycle mem_ready pulse.
interface mem_line_if;
    import mem_line_pkg::*;

    logic               mem_read;
    logic               mem_write;
    logic [LADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0]  mem_wdata;
    logic [LINE_W-1:0]  mem_rdata;
    logic               mem_ready;

    modport master (
        output mem_read, mem_write, mem_addr, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_read, mem_write, mem_addr, mem_wdata,
        output mem_rdata, mem_ready
    );

endinterface

// File: rtl/mem_line_responder_array.sv
// Single-port line RAM: registered read output (cleared by reset), storage kept across reset.
module mem_line_array
    import mem_line_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              rd_en_i,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic [LINE_W-1:0] wdata_i,
    output logic [LINE_W-1:0] rdata_o
);

    logic [LINE_W-1:0] mem [DEPTH];
    logic [LINE_W-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[idx_i] <= wdata_i;
        end
    end

    // Output register holds the last line read until the next read or reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= mem[idx_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_line_responder.sv
// Fixed-latency memory responder for the I/D cache line protocol.
// IDLE -> BUSY -> RESP -> GAP -> IDLE; one transaction in flight at a time.
module mem_line_responder
    import mem_line_pkg::*;
#(
    parameter int LATENCY = 4,
    parameter int DEPTH   = 256
) (
    input  logic      clk,
    input  logic      rst,
    mem_line_if.slave bus,
    output logic      busy,
    output logic      proto_err,
    output state_e    dbg_state
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    op_e                op_q, op_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [LINE_W-1:0]  wdata_q, wdata_d;
    logic               proto_err_q, proto_err_d;
    logic               req;
    logic               rd_en;
    logic               wr_en;
    logic               unused_addr_hi;

    assign req = bus.mem_read | bus.mem_write;
    // Upper line-address bits alias onto the array by truncation.
    assign unused_addr_hi = ^bus.mem_addr[LADDR_W-1:IDX_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            op_q        <= OP_RD;
            idx_q       <= '0;
            wdata_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        proto_err_d = proto_err_q;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    op_d    = bus.mem_write ? OP_WR : OP_RD;
                    idx_d   = bus.mem_addr[IDX_W-1:0];
                    wdata_d = bus.mem_wdata;
                    cnt_d   = CNT_W'(LATENCY - 1);
                    if (bus.mem_read && bus.mem_write) begin
                        proto_err_d = 1'b1;
                    end
                    state_d = (LATENCY == 1) ? S_RESP : S_BUSY;
                end
            end
            S_BUSY: begin
                if (!req) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    // Reaching zero here puts RESP exactly LATENCY cycles after acceptance.
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP:  state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Read is issued on the edge entering RESP so the registered line lands in the RESP cycle.
    assign rd_en = !rst && (state_d == S_RESP) && (op_d == OP_RD);
    assign wr_en = !rst && (state_q == S_RESP) && (op_q == OP_WR);

    mem_line_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk_i   (clk),
        .rst_i   (rst),
        .rd_en_i (rd_en),
        .wr_en_i (wr_en),
        .idx_i   (idx_d),
        .wdata_i (wdata_q),
        .rdata_o (bus.mem_rdata)
    );

    assign bus.mem_ready = (state_q == S_RESP);
    assign busy          = (state_q == S_BUSY) || (state_q == S_RESP);
    assign proto_err     = proto_err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_mem_line_responder.sv
// Directed bench for mem_line_responder: LATENCY=4 instance for most cases, LATENCY=2 for back-to-back.
module tb_mem_line_responder;
    import mem_line_pkg::*;

    logic   clk;
    logic   rst;
    logic   busy4, perr4, busy2, perr2;
    state_e st4, st2;
    int     n_tests = 0;
    int     n_fail  = 0;
    logic [127:0] exp_q[$];

    localparam logic [127:0] LINE_A5 = {16{8'hA5}};
    localparam logic [127:0] LINE_D  = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_F00D_CAFE;

    mem_line_if b4 ();
    mem_line_if b2 ();

    mem_line_responder #(.LATENCY(4), .DEPTH(256)) dut4 (
        .clk(clk), .rst(rst), .bus(b4), .busy(busy4), .proto_err(perr4), .dbg_state(st4)
    );
    mem_line_responder #(.LATENCY(2), .DEPTH(256)) dut2 (
        .clk(clk), .rst(rst), .bus(b2), .busy(busy2), .proto_err(perr2), .dbg_state(st2)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Full transaction on the LATENCY=4 port; scrambles addr/wdata after acceptance.
    // Returns in the next IDLE cycle.
    task automatic txn4(input logic rd, input logic wr, input logic [27:0] a,
                        input logic [127:0] d, output logic [127:0] rdata, output int lat);
        b4.mem_read  = rd;
        b4.mem_write = wr;
        b4.mem_addr  = a;
        b4.mem_wdata = d;
        lat = 0;
        do begin
            step();
            lat++;
            if (lat == 1) begin
                b4.mem_addr  = a ^ 28'hFF;
                b4.mem_wdata = ~d;
            end
        end while (!b4.mem_ready && lat < 20);
        rdata = b4.mem_rdata;
        b4.mem_read  = 1'b0;
        b4.mem_write = 1'b0;
        step();
        step();
    endtask

    task automatic write4(input logic [27:0] a, input logic [127:0] d);
        logic [127:0] r;
        int lat;
        txn4(1'b0, 1'b1, a, d, r, lat);
        check_eq("wr_latency", 128'(lat), 128'd4);
    endtask

    // Scoreboard read: compares against the head of exp_q.
    task automatic read4(input string tag, input logic [27:0] a);
        logic [127:0] r;
        int lat;
        txn4(1'b1, 1'b0, a, '0, r, lat);
        check_eq({tag, "_lat"}, 128'(lat), 128'd4);
        if (exp_q.size() == 0) begin
            check_eq({tag, "_noexp"}, 128'd0, 128'd1);
        end else begin
            check_eq(tag, r, exp_q.pop_front());
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [127:0] r;
        int lat;
        b4.mem_read = 1'b0; b4.mem_write = 1'b0; b4.mem_addr = '0; b4.mem_wdata = '0;
        b2.mem_read = 1'b0; b2.mem_write = 1'b0; b2.mem_addr = '0; b2.mem_wdata = '0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        check_eq("rst_ready", 128'(b4.mem_ready), 128'd0);
        check_eq("rst_busy", 128'(busy4), 128'd0);
        check_eq("rst_perr", 128'(perr4), 128'd0);
        check_eq("rst_rdata", b4.mem_rdata, 128'd0);
        check_eq("rst_state", 128'(st4), 128'(S_IDLE));

        // Back-to-back with request held high, LATENCY=2: ready at T+2 and T+6.
        b2.mem_read = 1'b1;
        b2.mem_addr = 28'd1;
        for (int k = 1; k <= 7; k++) begin
            step();
            check_eq($sformatf("b2b_ready_t%0d", k), 128'(b2.mem_ready),
                     128'((k == 2) || (k == 6)));
        end
        b2.mem_read = 1'b0;

        // Preload line 5 through the bus.
        write4(28'd5, LINE_A5);

        // Read of line 5 with per-cycle busy/ready timing.
        b4.mem_read = 1'b1;
        b4.mem_addr = 28'd5;
        check_eq("t1_busy_T", 128'(busy4), 128'd0);
        for (int k = 1; k <= 4; k++) begin
            step();
            if (k == 1) b4.mem_addr = 28'd0;
            check_eq($sformatf("t1_busy_t%0d", k), 128'(busy4), 128'd1);
            check_eq($sformatf("t1_ready_t%0d", k), 128'(b4.mem_ready), 128'(k == 4));
        end
        check_eq("t1_rdata", b4.mem_rdata, LINE_A5);
        b4.mem_read = 1'b0;
        step();
        check_eq("t1_ready_t5", 128'(b4.mem_ready), 128'd0);
        check_eq("t1_busy_t5", 128'(busy4), 128'd0);
        check_eq("t1_rdata_hold", b4.mem_rdata, LINE_A5);
        check_eq("t1_state_gap", 128'(st4), 128'(S_GAP));
        step();

        // Write ignores wdata/addr changes after acceptance.
        write4(28'd3, 128'h1234);
        exp_q.push_back(128'h1234);
        read4("t2_rdata", 28'd3);

        // Read and write together: treated as write, sticky error.
        txn4(1'b1, 1'b1, 28'd7, LINE_D, r, lat);
        check_eq("t3_lat", 128'(lat), 128'd4);
        check_eq("t3_perr", 128'(perr4), 128'd1);
        exp_q.push_back(LINE_D);
        read4("t3_rdata", 28'd7);
        check_eq("t3_perr_sticky", 128'(perr4), 128'd1);

        // Abort: write to line 9 dropped at T+2 leaves the old line in place.
        write4(28'd9, 128'h99);
        b4.mem_write = 1'b1;
        b4.mem_addr  = 28'd9;
        b4.mem_wdata = 128'h55;
        step();
        check_eq("t5_ready_t1", 128'(b4.mem_ready), 128'd0);
        step();
        check_eq("t5_ready_t2", 128'(b4.mem_ready), 128'd0);
        b4.mem_write = 1'b0;
        step();
        check_eq("t5_busy_t3", 128'(busy4), 128'd0);
        check_eq("t5_ready_t3", 128'(b4.mem_ready), 128'd0);
        check_eq("t5_state_t3", 128'(st4), 128'(S_IDLE));
        exp_q.push_back(128'h99);
        read4("t5_rdata", 28'd9);

        // Aliasing: line 261 maps to line 5.
        exp_q.push_back(LINE_A5);
        read4("t6_alias", 28'd261);

        // Reset while BUSY.
        b4.mem_read = 1'b1;
        b4.mem_addr = 28'd3;
        step();
        check_eq("t6_busy_pre", 128'(busy4), 128'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        b4.mem_read = 1'b0;
        check_eq("t6_ready", 128'(b4.mem_ready), 128'd0);
        check_eq("t6_busy", 128'(busy4), 128'd0);
        check_eq("t6_rdata", b4.mem_rdata, 128'd0);
        check_eq("t6_perr", 128'(perr4), 128'd0);
        check_eq("t6_state", 128'(st4), 128'(S_IDLE));
        step();
        exp_q.push_back(LINE_A5);
        read4("t6_kept", 28'd5);

        // Reset during the RESP cycle of a write discards it.
        b4.mem_write = 1'b1;
        b4.mem_addr  = 28'd5;
        b4.mem_wdata = 128'hBAD;
        repeat (4) step();
        check_eq("t7_ready", 128'(b4.mem_ready), 128'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        b4.mem_write = 1'b0;
        step();
        exp_q.push_back(LINE_A5);
        read4("t7_discard", 28'd5);

        check_eq("sb_empty", 128'(exp_q.size()), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
